exec_unit: RTL and testbench

Execute stage of the 24-bit CPU. It sits between operand read and the register-file write port. It accepts one operation per handshake, computes on the two read operands, and drives the write-back triple (`we`, `dst`, `data`) straight into the register file.
- Single-cycle ops: ADD, SUB, AND, OR, XOR, SHL, SHR, MOV, CMP.
- Multi-cycle op: MUL, a 24-iteration shift-add multiplier.

---
 rtl/exec_unit_pkg.sv | 21 ++
 rtl/exec_unit_mul_seq.sv | 50 +++++
 rtl/exec_unit.sv | 149 ++++++++++++++
 tb/tb_exec_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/exec_unit_pkg.sv
// Shared constants for the execute stage: opcodes and FSM state encodings.
package exec_unit_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_WB   = 2'd2
  } state_e;

endpackage

// File: rtl/exec_unit_mul_seq.sv
// Shift-add multiplier: one partial product per cycle, LSB of multiplier first.
// product is the combinational next value of the accumulator, so it is the
// complete result exactly in the cycle done is high.
module mul_seq #(
  parameter int WIDTH      = 24,
  parameter int MUL_CYCLES = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic               r_run;
  logic [4:0]         r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [2*WIDTH-1:0] r_p;     // {partial sum, remaining multiplier bits}
  logic [WIDTH:0]     w_sum;

  assign w_sum   = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_a} : '0);
  assign product = {w_sum, r_p[WIDTH-1:1]};
  assign done    = r_run && (r_cnt == 5'(MUL_CYCLES - 1));

  // Load operands on start, then one add/shift step per cycle until done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_run <= 1'b0;
      r_cnt <= '0;
      r_a   <= '0;
      r_p   <= '0;
    end else if (start) begin
      r_run <= 1'b1;
      r_cnt <= '0;
      r_a   <= a;
      r_p   <= {{WIDTH{1'b0}}, b};
    end else if (r_run) begin
      r_p <= product;
      if (done) begin
        r_run <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 5'd1;
      end
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU inline, MUL via mul_seq, registered
// write-back triple and flags driven straight into the register file.
module exec_unit
  import exec_unit_pkg::*;
#(
  parameter int WIDTH      = 24,
  parameter int MUL_CYCLES = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [3:0]       op,
  input  logic [3:0]       dst_in,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             we,
  output logic [3:0]       dst,
  output logic [WIDTH-1:0] data,
  output logic             zero,
  output logic             carry,
  output logic             busy
);

  state_e r_state, w_state_nxt;

  logic               r_we, r_zero, r_carry;
  logic [3:0]         r_dst, r_mdst;
  logic [WIDTH-1:0]   r_data;

  logic               w_acc, w_is_mul, w_mul_done, w_done_raw;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res;
  logic               w_cry, w_wr, w_def;
  logic [4:0]         w_k;
  logic [WIDTH:0]     w_sum, w_dif, w_shl, w_shr;

  assign issue_ready = (r_state != ST_MUL);
  assign busy        = (r_state == ST_MUL);
  assign w_acc       = issue_valid && issue_ready;
  assign w_is_mul    = (op == OP_MUL);
  assign w_mul_done  = (r_state == ST_MUL) && w_done_raw;

  assign we    = r_we;
  assign dst   = r_dst;
  assign data  = r_data;
  assign zero  = r_zero;
  assign carry = r_carry;

  mul_seq #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_acc && w_is_mul),
    .a       (opa),
    .b       (opb),
    .done    (w_done_raw),
    .product (w_prod)
  );

  // Extended-width intermediates: the extra bit carries out/borrow/shifted-out bit.
  assign w_k   = opb[4:0];
  assign w_sum = {1'b0, opa} + {1'b0, opb};
  assign w_dif = {1'b0, opa} - {1'b0, opb};
  assign w_shl = {1'b0, opa} << w_k;
  assign w_shr = {opa, 1'b0} >> w_k;

  // Single-cycle ALU: result, carry, write flag, and whether the opcode is defined.
  always_comb begin
    w_res = '0;
    w_cry = 1'b0;
    w_wr  = 1'b1;
    w_def = 1'b1;
    case (op)
      OP_ADD: {w_cry, w_res} = w_sum;
      OP_SUB: {w_cry, w_res} = w_dif;
      OP_AND: w_res = opa & opb;
      OP_OR:  w_res = opa | opb;
      OP_XOR: w_res = opa ^ opb;
      OP_SHL: begin
        if (w_k == 5'd0)               w_res = opa;
        else if (w_k <= 5'(WIDTH)) {w_cry, w_res} = w_shl;
      end
      OP_SHR: begin
        if (w_k == 5'd0)               w_res = opa;
        else if (w_k <= 5'(WIDTH)) {w_res, w_cry} = w_shr;
      end
      OP_MOV: w_res = opb;
      OP_CMP: begin
        {w_cry, w_res} = w_dif;
        w_wr = 1'b0;
      end
      default: begin
        w_wr  = 1'b0;
        w_def = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: accepts from IDLE/WB, MUL holds until the multiplier finishes.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_WB: begin
        if (w_acc) w_state_nxt = w_is_mul ? ST_MUL : ST_WB;
        else       w_state_nxt = ST_IDLE;
      end
      ST_MUL:  if (w_mul_done) w_state_nxt = ST_WB;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Write-back triple and flags, all captured on entry to WB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_dst   <= '0;
      r_mdst  <= '0;
      r_data  <= '0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_mul_done) begin
        r_we    <= 1'b1;
        r_dst   <= r_mdst;
        r_data  <= w_prod[WIDTH-1:0];
        r_zero  <= (w_prod[WIDTH-1:0] == '0);
        r_carry <= |w_prod[2*WIDTH-1:WIDTH];
      end else if (w_acc) begin
        if (w_is_mul) begin
          r_mdst <= dst_in;
        end else if (w_def) begin
          r_we    <= w_wr;
          r_dst   <= dst_in;
          if (w_wr) r_data <= w_res;
          r_zero  <= (w_res == '0);
          r_carry <= w_cry;
        end
      end
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: drives ops one clock apart and checks the
// write-back triple and flags one time unit after each rising edge.
module tb_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [3:0]  op = 4'd0;
  logic [3:0]  dst_in = 4'd0;
  logic [23:0] opa = 24'd0;
  logic [23:0] opb = 24'd0;
  logic        we;
  logic [3:0]  dst;
  logic [23:0] data;
  logic        zero;
  logic        carry;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exec_unit #(.WIDTH(24), .MUL_CYCLES(24)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .op(op), .dst_in(dst_in), .opa(opa), .opb(opb),
    .we(we), .dst(dst), .data(data), .zero(zero), .carry(carry), .busy(busy)
  );

  task automatic drive(input logic [3:0] o, input logic [3:0] d, input logic [23:0] a, input logic [23:0] b);
    issue_valid = 1'b1; op = o; dst_in = d; opa = a; opb = b;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; issue_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++; if (we !== 1'b0)        begin errors++; $display("FAIL reset_we got %b exp 0", we); end
    checks++; if (dst !== 4'd0)       begin errors++; $display("FAIL reset_dst got %0d exp 0", dst); end
    checks++; if (data !== 24'd0)     begin errors++; $display("FAIL reset_data got %h exp 0", data); end
    checks++; if ({zero, carry} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {zero, carry}); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", issue_ready); end
  endtask

  task automatic test_add_overflow();
    drive(4'd0, 4'd5, 24'hFFFFFF, 24'h000001);
    tick();
    issue_valid = 1'b0;
    checks++; if (we !== 1'b1)    begin errors++; $display("FAIL add_we got %b exp 1", we); end
    checks++; if (dst !== 4'd5)   begin errors++; $display("FAIL add_dst got %0d exp 5", dst); end
    checks++; if (data !== 24'd0) begin errors++; $display("FAIL add_data got %h exp 000000", data); end
    checks++; if ({zero, carry} !== 2'b11) begin errors++; $display("FAIL add_flags got %b exp 11", {zero, carry}); end
    tick();
    checks++; if (we !== 1'b0)    begin errors++; $display("FAIL add_idle_we got %b exp 0", we); end
  endtask

  task automatic test_sub_cmp();
    drive(4'd1, 4'd2, 24'd3, 24'd5);
    tick();
    checks++; if (we !== 1'b1)          begin errors++; $display("FAIL sub_we got %b exp 1", we); end
    checks++; if (data !== 24'hFFFFFE)  begin errors++; $display("FAIL sub_data got %h exp fffffe", data); end
    checks++; if ({zero, carry} !== 2'b01) begin errors++; $display("FAIL sub_flags got %b exp 01", {zero, carry}); end
    drive(4'd9, 4'd3, 24'd7, 24'd7);
    tick();
    issue_valid = 1'b0;
    checks++; if (we !== 1'b0)          begin errors++; $display("FAIL cmp_we got %b exp 0", we); end
    checks++; if ({zero, carry} !== 2'b10) begin errors++; $display("FAIL cmp_flags got %b exp 10", {zero, carry}); end
    tick();
  endtask

  task automatic test_shifts();
    drive(4'd5, 4'd1, 24'h800001, 24'd1);
    tick();
    checks++; if (data !== 24'h000002) begin errors++; $display("FAIL shl1_data got %h exp 000002", data); end
    checks++; if ({zero, carry} !== 2'b01) begin errors++; $display("FAIL shl1_flags got %b exp 01", {zero, carry}); end
    drive(4'd6, 4'd1, 24'hFFFFFF, 24'd25);
    tick();
    checks++; if (data !== 24'd0)      begin errors++; $display("FAIL shr25_data got %h exp 000000", data); end
    checks++; if ({zero, carry} !== 2'b10) begin errors++; $display("FAIL shr25_flags got %b exp 10", {zero, carry}); end
    drive(4'd6, 4'd1, 24'h800000, 24'd24);
    tick();
    checks++; if ({data, zero, carry} !== {24'd0, 2'b11}) begin errors++; $display("FAIL shr24 got %h/%b exp 000000/11", data, {zero, carry}); end
    drive(4'd6, 4'd1, 24'h00ABCD, 24'd0);
    tick();
    issue_valid = 1'b0;
    checks++; if ({data, zero, carry} !== {24'h00ABCD, 2'b00}) begin errors++; $display("FAIL shr0 got %h/%b exp 00abcd/00", data, {zero, carry}); end
    tick();
  endtask

  task automatic run_mul(input logic [23:0] a, input logic [23:0] b, input logic [3:0] d,
                         input logic [23:0] exp_data, input logic exp_carry, input string nm);
    int bad;
    drive(4'd8, d, a, b);
    tick();
    issue_valid = 1'b0;
    opa = 24'h5A5A5A; opb = 24'hA5A5A5;   // operands must already be held internally
    bad = 0;
    repeat (24) begin
      if (issue_ready !== 1'b0 || busy !== 1'b1 || we !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad != 0)  begin errors++; $display("FAIL %s_busy_window got %0d bad cycles exp 0", nm, bad); end
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL %s_we_at_25 got %b exp 1", nm, we); end
    checks++; if (dst !== d) begin errors++; $display("FAIL %s_dst got %0d exp %0d", nm, dst, d); end
    checks++; if (data !== exp_data) begin errors++; $display("FAIL %s_data got %h exp %h", nm, data, exp_data); end
    checks++; if (carry !== exp_carry) begin errors++; $display("FAIL %s_carry got %b exp %b", nm, carry, exp_carry); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_wb got %b exp 1", nm, issue_ready); end
    tick();
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL %s_single_write got %b exp 0", nm, we); end
  endtask

  task automatic test_mul();
    run_mul(24'h001000, 24'h001000, 4'd6, 24'd0, 1'b1, "mul_ovf");
    run_mul(24'd1234, 24'd10, 4'd7, 24'd12340, 1'b0, "mul_small");
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      drive(4'd0, 4'(i), 24'(i), 24'(i * 100));
      tick();
      checks++;
      if (we !== 1'b1 || dst !== 4'(i) || data !== 24'(i * 101))
        begin errors++; $display("FAIL b2b_%0d got we=%b dst=%0d data=%0d exp 1/%0d/%0d", i, we, dst, data, i, i * 101); end
    end
    issue_valid = 1'b0;
    tick();
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL b2b_end_we got %b exp 0", we); end
  endtask

  task automatic test_illegal();
    drive(4'd0, 4'd9, 24'hFFFFFF, 24'd1);   // leaves zero=1, carry=1
    tick();
    drive(4'd15, 4'd4, 24'd3, 24'd4);
    tick();
    issue_valid = 1'b0;
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL nop_we got %b exp 0", we); end
    checks++; if ({zero, carry} !== 2'b11) begin errors++; $display("FAIL nop_flags got %b exp 11", {zero, carry}); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL nop_ready got %b exp 1", issue_ready); end
    tick();
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL nop_after_we got %b exp 0", we); end
  endtask

  task automatic test_reset_mid_mul();
    int wr;
    drive(4'd8, 4'd8, 24'd3, 24'd3);
    tick();                                 // MUL cycle 1
    issue_valid = 1'b0;
    repeat (9) tick();                      // MUL cycle 10
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmul_busy_before got %b exp 1", busy); end
    rst_n = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || issue_ready !== 1'b1)
      begin errors++; $display("FAIL rmul_state got busy=%b ready=%b exp 0/1", busy, issue_ready); end
    checks++; if ({we, dst, data, zero, carry} !== 31'd0)
      begin errors++; $display("FAIL rmul_outputs got we=%b dst=%0d data=%h z=%b c=%b exp all 0", we, dst, data, zero, carry); end
    rst_n = 1'b1;
    wr = 0;
    repeat (20) begin
      tick();
      if (we !== 1'b0 || busy !== 1'b0) wr++;
    end
    checks++; if (wr != 0) begin errors++; $display("FAIL rmul_no_write got %0d cycles exp 0", wr); end
    drive(4'd0, 4'd11, 24'd2, 24'd3);
    tick();
    issue_valid = 1'b0;
    checks++; if (we !== 1'b1 || dst !== 4'd11 || data !== 24'd5)
      begin errors++; $display("FAIL rmul_add got we=%b dst=%0d data=%0d exp 1/11/5", we, dst, data); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_cmp();
    test_shifts();
    test_mul();
    test_back_to_back();
    test_illegal();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
